// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit that owns the HI/LO registers.
// Optional feature macro MDU_MADD_EN: 4-bit op adding MADD/MADDU/MSUB/MSUBU.
module mdu_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef MDU_MADD_EN
  input  logic [3:0]       op,
`else
  input  logic [2:0]       op,
`endif
  input  logic             cancel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 32'sd1) ? $clog2(MAXC) : 32'sd1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 32'sd1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 32'sd1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   tmp_hi_r;
  logic [WIDTH-1:0]   tmp_lo_r;

  logic [3:0]         op_s;
  logic               is_mul_s;
  logic               is_div_s;
  logic               accept_s;
  logic               go_s;
  logic [2*WIDTH-1:0] sprod_s;
  logic [2*WIDTH-1:0] uprod_s;
  logic [2*WIDTH-1:0] res_s;

`ifdef MDU_MADD_EN
  assign op_s = op;
`else
  assign op_s = {1'b0, op};
`endif

  assign sprod_s  = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign uprod_s  = {ZERO, A} * {ZERO, B};
  assign accept_s = start & ~cancel & ~busy;
  assign go_s     = accept_s & (is_mul_s | is_div_s);
  assign stall    = busy | (start & (is_mul_s | is_div_s) & ~cancel);

  // Classify the requested op as a multiply-class or divide-class operation.
  always_comb begin
    is_mul_s = 1'b0;
    is_div_s = 1'b0;
    case (op_s)
      OP_MULT, OP_MULTU: is_mul_s = 1'b1;
      OP_DIV, OP_DIVU:   is_div_s = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_s = 1'b1;
`endif
      default: begin
        is_mul_s = 1'b0;
        is_div_s = 1'b0;
      end
    endcase
  end

  // Compute the {hi,lo} result that will be committed at the end of RUN.
  always_comb begin
    res_s = {hi, lo};
    case (op_s)
      OP_MULT:  res_s = sprod_s;
      OP_MULTU: res_s = uprod_s;
      OP_DIV: begin
        // Zero divisor keeps HI/LO; MOST_NEG / -1 saturates to MOST_NEG with zero remainder.
        if (B == ZERO) begin
          res_s = {hi, lo};
        end else if ((A == MOST_NEG) && (B == ALL_ONE)) begin
          res_s = {ZERO, MOST_NEG};
        end else begin
          res_s = {$signed(A) % $signed(B), $signed(A) / $signed(B)};
        end
      end
      OP_DIVU: begin
        if (B == ZERO) begin
          res_s = {hi, lo};
        end else begin
          res_s = {A % B, A / B};
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res_s = {hi, lo} + sprod_s;
      OP_MADDU: res_s = {hi, lo} + uprod_s;
      OP_MSUB:  res_s = {hi, lo} - sprod_s;
      OP_MSUBU: res_s = {hi, lo} - uprod_s;
`endif
      default:  res_s = {hi, lo};
    endcase
  end

  // Control FSM: launch, count down the latency, then commit HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      tmp_hi_r <= ZERO;
      tmp_lo_r <= ZERO;
      busy     <= 1'b0;
      hi       <= ZERO;
      lo       <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (go_s) begin
            tmp_hi_r <= res_s[2*WIDTH-1:WIDTH];
            tmp_lo_r <= res_s[WIDTH-1:0];
            cnt_r    <= is_div_s ? DIV_LOAD : MUL_LOAD;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else if (accept_s && (op_s == OP_MTHI)) begin
            hi <= A;
          end else if (accept_s && (op_s == OP_MTLO)) begin
            lo <= A;
          end
        end
        RUN: begin
          if (cnt_r == {CW{1'b0}}) begin
            hi      <= tmp_hi_r;
            lo      <= tmp_lo_r;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1'b1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit; successor to the single-cycle combinational ALU.
- Sits in the EX stage beside the ALU and owns the HI/LO architectural registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and exposes HI/LO for MFHI/MFLO.
- Latency is modelled with a counter so the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  op request; qualified by op, sampled on the rising edge.
- op  in  3  operation code, see Behaviour.
- cancel  in  1  same-cycle kill from exception logic; suppresses the start sampled this cycle.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- busy  out  1  registered; high while a mul/div is in flight.
- stall  out  1  combinational: busy | (start & op is MULT/MULTU/DIV/DIVU & ~cancel).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Op encoding: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved. Reserved behaves as NOP.
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, state=IDLE, counter=0. Reset mid-operation discards the pending result.
- FSM states are IDLE, RUN.
- IDLE to RUN: on an edge where start=1, cancel=0 and op is 1..4.
  - On that edge, compute the result from A/B and latch it into internal tmp_hi/tmp_lo.
  - Load counter = MUL_CYCLES-1 for ops 1..2, or DIV_CYCLES-1 for ops 3..4.
  - Set busy=1.
- RUN: the counter decrements each edge. On the edge where counter==0:
  - hi<=tmp_hi, lo<=tmp_lo.
  - busy<=0, state<=IDLE.
- Timing: start sampled at edge t0 gives busy=1 for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES), and the new hi/lo are visible after edge t0+N.
- MULT: {hi,lo} = signed(A)*signed(B), 2*WIDTH bits.
- MULTU: unsigned product.
- DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIVU: unsigned quotient/remainder.
- Divide by zero (B==0): the op still runs its full DIV_CYCLES, but hi/lo remain unchanged at commit.
- DIV overflow (A = most-negative, B = -1): lo = most-negative, hi = 0.
- MTHI/MTLO: when start=1, cancel=0 and busy=0, hi<=A (or lo<=A) on the same edge. No busy.
- start while busy=1: ignored entirely, including MTHI/MTLO. The pipeline must hold the instruction, which stall guarantees.
- cancel=1 with start=1: no state change. cancel has no effect on an op already in RUN.
- hi/lo read during RUN return the old values. The pipeline stalls MFHI/MFLO on stall.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, reserved op 7 is replaced with a 4-bit op port, adding:
  - 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU.
  - Result: {hi,lo} <= {hi,lo} ± product, wrap modulo 2^(2*WIDTH).
  - The accumulate uses the hi/lo values current at the start edge.
  - Busy for MUL_CYCLES.
- When undefined: op is 3 bits and codes 8..11 do not exist.

Test Plan:
- MULT, A=32'hFFFF_FFFE (-2), B=3 -> busy high for exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA. stall high on the start cycle.
- DIV, A=-7, B=2 -> busy for 10 cycles; then lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
- DIVU, A=7, B=2 -> lo=3, hi=1. Then DIV with B=0 -> 10 busy cycles, hi/lo still 1/3.
- MTHI, A=32'h1234_5678, issued during a MULTU busy window -> ignored. Reissued when idle -> hi=32'h1234_5678 next edge with busy=0.
- MULT with start=1, cancel=1 -> busy stays 0 and hi/lo unchanged.
- Reset: assert reset_n=0 at busy cycle 3 of a DIV -> hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
- With MDU_MADD_EN defined: hi=0, lo=32'hFFFF_FFFF, then MADDU with A=1, B=1 -> hi=1, lo=0.
